// File: rtl/hyper_arbiter.sv
// Two-port round-robin arbiter sharing one hyper_xface HyperRAM controller.
// Serialises single-dword reads/writes and returns data/error to the winning port.
module hyper_arbiter #(
  parameter int START_TIMEOUT = 16,
  parameter int END_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        rd_req,
  output logic        wr_req,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic [3:0]  wr_byte_en,
  output logic [5:0]  rd_num_dwords,
  output logic        mem_or_reg,
  input  logic        busy,
  input  logic        rd_rdy,
  input  logic [31:0] rd_d,
  output logic [1:0]  grant
);

  localparam logic [7:0] START_LIMIT = 8'(START_TIMEOUT);
  localparam logic [7:0] END_LIMIT   = 8'(END_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_END} state_t;

  state_t      state, state_next;
  logic [7:0]  timer;
  logic        last;
  logic        owner;
  logic        cur_we;
  logic        got_rdy;
  logic        take;
  logic        take_port;
  logic        finish;
  logic        finish_err;

  assign rd_num_dwords = 6'd1;
  assign mem_or_reg    = 1'b0;

  // Grants are held off during the done cycle so the finishing port can drop req.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    take_port  = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (!p0_done && !p1_done && !busy && (p0_req || p1_req)) begin
          take       = 1'b1;
          take_port  = (p0_req && p1_req) ? ~last : p1_req;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_START;
      WAIT_START: begin
        if (busy) begin
          state_next = WAIT_END;
        end else if (timer >= START_LIMIT) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      WAIT_END: begin
        if (!busy) begin
          finish     = 1'b1;
          finish_err = !cur_we && !got_rdy && !rd_rdy;
        end else if (timer >= END_LIMIT) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (finish) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) timer <= '0;
      else if (timer != 8'hFF) timer <= timer + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      cur_we     <= 1'b0;
      got_rdy    <= 1'b0;
      grant      <= 2'b00;
      addr       <= '0;
      wr_d       <= '0;
      wr_byte_en <= '0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      rd_req  <= 1'b0;
      wr_req  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;

      if (take) begin
        owner      <= take_port;
        last       <= take_port;
        got_rdy    <= 1'b0;
        grant      <= take_port ? 2'b10 : 2'b01;
        cur_we     <= take_port ? p1_we    : p0_we;
        addr       <= take_port ? p1_addr  : p0_addr;
        wr_d       <= take_port ? p1_wdata : p0_wdata;
        wr_byte_en <= take_port ? p1_be    : p0_be;
      end

      if (state == ISSUE) begin
        wr_req <= cur_we;
        rd_req <= !cur_we;
      end

      if (state == WAIT_END && rd_rdy) begin
        got_rdy <= 1'b1;
        if (owner) p1_rdata <= rd_d;
        else       p0_rdata <= rd_d;
      end

      if (finish) begin
        grant <= 2'b00;
        if (owner) begin
          p1_done <= 1'b1;
          p1_err  <= finish_err;
        end else begin
          p0_done <= 1'b1;
          p0_err  <= finish_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_hyper_arbiter.sv
// Scoreboard bench for hyper_arbiter: a behavioural HyperRAM model answers strobes,
// a reference model predicts grant order, data, error and latency per transaction.
module tb_hyper_arbiter;

  localparam int START_TIMEOUT = 16;
  localparam int END_TIMEOUT   = 255;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic [3:0]  p0_be = '0, p1_be = '0;
  logic        p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        rd_req, wr_req;
  logic [31:0] addr, wr_d;
  logic [3:0]  wr_byte_en;
  logic [5:0]  rd_num_dwords;
  logic        mem_or_reg;
  logic        busy = 1'b0, rd_rdy = 1'b0;
  logic [31:0] rd_d = '0;
  logic [1:0]  grant;

  hyper_arbiter #(.START_TIMEOUT(START_TIMEOUT), .END_TIMEOUT(END_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_d(wr_d), .wr_byte_en(wr_byte_en),
    .rd_num_dwords(rd_num_dwords), .mem_or_reg(mem_or_reg),
    .busy(busy), .rd_rdy(rd_rdy), .rd_d(rd_d), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        port;
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit        err;
    bit [31:0] rdata;
    int        lat;
  } exp_t;

  exp_t exp_strobe[$];
  exp_t exp_done0[$];
  exp_t exp_done1[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cyc = 0;

  // mode 0: normal, 1: busy never rises, 2: reads end without rd_rdy
  int mode = 0;
  int dly = 3;
  int blen = 4;

  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] model_mem [bit [31:0]];
  bit [31:0] ref_rdata [2];
  bit        last_won = 1'b1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic bit [31:0] ref_read(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Reference model: predicts the outcome of one granted transaction.
  function automatic void expect_txn(input bit port);
    exp_t e;
    e.port  = port;
    e.we    = port ? p1_we    : p0_we;
    e.addr  = port ? p1_addr  : p0_addr;
    e.wdata = port ? p1_wdata : p0_wdata;
    e.be    = port ? p1_be    : p0_be;
    e.err   = (mode == 1) || (mode == 2 && !e.we);
    e.lat   = (mode == 1) ? START_TIMEOUT + 1 : dly + blen + 1;
    if (!e.we && !e.err) ref_rdata[port] = ref_read(e.addr);
    e.rdata = ref_rdata[port];
    if (e.we) ref_mem[e.addr] = merge(ref_read(e.addr), e.wdata, e.be);
    exp_strobe.push_back(e);
    if (port) exp_done1.push_back(e);
    else      exp_done0.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // HyperRAM controller model: busy rises dly cycles after the strobe for blen cycles.
  bit        m_active = 1'b0;
  bit        m_rd = 1'b0;
  int        m_cnt = 0;
  bit [31:0] m_data = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_active = 1'b0;
      end else if (rd_req || wr_req) begin
        m_active = (mode != 1);
        m_cnt    = 0;
        m_rd     = rd_req;
        m_data   = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
        if (wr_req) model_mem[addr] = merge(m_data, wr_d, wr_byte_en);
      end else if (m_active) begin
        m_cnt++;
      end
      busy   = m_active && m_cnt >= dly && m_cnt < dly + blen;
      rd_rdy = m_active && m_rd && mode != 2 && m_cnt == dly + blen - 1;
      rd_d   = rd_rdy ? m_data : $urandom;
      if (m_active && m_cnt >= dly + blen) m_active = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or a done.
  exp_t me;
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_req || wr_req) begin
        if (exp_strobe.size() == 0) begin
          check("unexpected_strobe", 32'(1), 32'(0));
        end else begin
          me = exp_strobe.pop_front();
          check("strobe_kind", 32'({rd_req, wr_req}), me.we ? 32'd1 : 32'd2);
          check("strobe_addr", addr, me.addr);
          check("strobe_wdata", wr_d, me.wdata);
          check("strobe_be", 32'(wr_byte_en), 32'(me.be));
          check("strobe_grant", 32'(grant), me.port ? 32'd2 : 32'd1);
        end
        strobe_cyc = cyc;
      end
      if (p0_done || p1_done) check("dual_done", 32'(p0_done && p1_done), 32'(0));
      if (p0_done) begin
        if (exp_done0.size() == 0) begin
          check("unexpected_p0_done", 32'(1), 32'(0));
        end else begin
          me = exp_done0.pop_front();
          check("p0_err", 32'(p0_err), 32'(me.err));
          check("p0_rdata", p0_rdata, me.rdata);
          check("p0_latency", 32'(cyc - strobe_cyc), 32'(me.lat));
        end
      end
      if (p1_done) begin
        if (exp_done1.size() == 0) begin
          check("unexpected_p1_done", 32'(1), 32'(0));
        end else begin
          me = exp_done1.pop_front();
          check("p1_err", 32'(p1_err), 32'(me.err));
          check("p1_rdata", p1_rdata, me.rdata);
          check("p1_latency", 32'(cyc - strobe_cyc), 32'(me.lat));
        end
      end
    end
  end

  task automatic setup_port(input bit port, input bit we, input bit [31:0] a,
                            input bit [31:0] d, input bit [3:0] be);
    if (port) begin
      p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
    end else begin
      p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
    end
  endtask

  // Issues requests on the selected ports and holds each until its done.
  task automatic applyStimulus(input bit u0, input bit u1);
    int  n = 0;
    bit  seen = 1'b0;
    bit  first;
    if (u0 && u1) begin
      first = ~last_won;
      expect_txn(first);
      expect_txn(~first);
      last_won = ~first;
    end else begin
      expect_txn(u1);
      last_won = u1;
    end
    p0_req = u0;
    p1_req = u1;
    while ((p0_req || p1_req) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (!seen && (rd_req || wr_req)) begin
        seen = 1'b1;
        check("req_to_strobe", 32'(n), 32'(2));
      end
      if (p0_done) p0_req = 1'b0;
      if (p1_done) p1_req = 1'b0;
    end
    if (p0_req || p1_req) begin
      check("txn_budget", 32'({p0_req, p1_req}), 32'(0));
      p0_req = 1'b0;
      p1_req = 1'b0;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    last_won = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput_reset(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'(0));
    check({tag, "_rd_req"}, 32'(rd_req), 32'(0));
    check({tag, "_wr_req"}, 32'(wr_req), 32'(0));
    check({tag, "_p0_done"}, 32'(p0_done), 32'(0));
    check({tag, "_p1_done"}, 32'(p1_done), 32'(0));
    check({tag, "_p0_err"}, 32'(p0_err), 32'(0));
    check({tag, "_p1_err"}, 32'(p1_err), 32'(0));
    check({tag, "_addr"}, addr, 32'(0));
    check({tag, "_wr_d"}, wr_d, 32'(0));
    check({tag, "_be"}, 32'(wr_byte_en), 32'(0));
    check({tag, "_p0_rdata"}, p0_rdata, 32'(0));
    check({tag, "_p1_rdata"}, p1_rdata, 32'(0));
  endtask

  initial begin
    int n;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput_reset("reset");
    check("rd_num_dwords", 32'(rd_num_dwords), 32'(1));
    check("mem_or_reg", 32'(mem_or_reg), 32'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single write on port 0, then read it back on port 1
    mode = 0; dly = 3; blen = 20;
    setup_port(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 1'b0);
    setup_port(1, 1'b0, 32'h10, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1);

    // Simultaneous requests straight after reset, twice
    do_reset();
    dly = 2; blen = 3;
    setup_port(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    setup_port(1, 1'b1, 32'h24, 32'h55667788, 4'hF);
    applyStimulus(1'b1, 1'b1);
    setup_port(0, 1'b0, 32'h24, 32'h0, 4'h0);
    setup_port(1, 1'b0, 32'h20, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1);

    // busy never rises, then a normal request
    mode = 1;
    setup_port(0, 1'b0, 32'h10, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0);
    mode = 0;
    setup_port(1, 1'b1, 32'h28, 32'hCAFEF00D, 4'h5);
    applyStimulus(1'b0, 1'b1);

    // Read ending without rd_rdy keeps the previous rdata
    setup_port(0, 1'b0, 32'h20, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0);
    mode = 2;
    setup_port(0, 1'b0, 32'h24, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0);
    mode = 0;

    // Reset pulsed while the transaction sits in WAIT_END
    dly = 2; blen = 20;
    setup_port(0, 1'b0, 32'h20, 32'h0, 4'h0);
    expect_txn(1'b0);
    void'(exp_done0.pop_back());
    p0_req = 1'b1;
    n = 0;
    while (!busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_seen", 32'(busy), 32'(1));
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput_reset("midreset");
    p0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    last_won = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    @(posedge clk);
    #1;
    dly = 1; blen = 2;
    setup_port(0, 1'b0, 32'h10, 32'h0, 4'h0);
    setup_port(1, 1'b0, 32'h28, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      int pat;
      int r;
      pat  = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      dly  = $urandom_range(1, 5);
      blen = $urandom_range(2, 6);
      for (int p = 0; p < 2; p++)
        setup_port(p[0], 1'($urandom_range(0, 1)), {27'd0, 3'($urandom_range(0, 7)), 2'b00},
                   $urandom, 4'($urandom_range(1, 15)));
      applyStimulus(pat != 1, pat != 0);
    end
    mode = 0;

    check("queues_empty", 32'(exp_strobe.size() + exp_done0.size() + exp_done1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
